// File: rtl/mem_pkg.sv
// Shared types and default sizing for the burst memory front-end.
package mem_pkg;

  localparam int unsigned DATA_BITS_DEF = 32;
  localparam int unsigned MEM_SIZE_DEF  = 128;
  localparam int unsigned MAX_BURST_DEF = 16;
  localparam int unsigned MAX_OUTST_DEF = 2;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_typ_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } burst_state_e;

endpackage

// File: rtl/mem_outst_cnt.sv
// Up/down counter of memory requests issued but not yet answered.
module mem_outst_cnt #(
  parameter int unsigned MAX_OUTST = 2,
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign full = (cnt == CNT_W'(MAX_OUTST));

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst front-end: splits one burst command into pipelined single-word
// memory requests and streams write data in / read data out.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned MEM_SIZE  = MEM_SIZE_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEF,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE),
  localparam int unsigned LEN_WIDTH  = $clog2(MAX_BURST) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_val_i,
  output logic                  cmd_rdy_o,
  input  logic                  cmd_typ_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  output logic                  cmd_err_o,
  input  logic                  wdata_val_i,
  output logic                  wdata_rdy_o,
  input  logic [DATA_BITS-1:0]  wdata_i,
  output logic                  rdata_val_o,
  input  logic                  rdata_rdy_i,
  output logic [DATA_BITS-1:0]  rdata_o,
  output logic                  rdata_last_o,
  output logic                  done_o,
  output logic                  mem_req_val_o,
  input  logic                  mem_req_rdy_i,
  output logic                  mem_req_typ_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [DATA_BITS-1:0]  mem_req_data_o,
  input  logic                  mem_rsp_val_i,
  output logic                  mem_rsp_rdy_o,
  input  logic [DATA_BITS-1:0]  mem_rsp_data_i
);

  localparam int unsigned OUTST_W = $clog2(MAX_OUTST + 1);

  burst_state_e          state_q, state_d;
  req_typ_e              typ_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q, issued_q, received_q, received_nxt;
  logic                  err_q;
  logic [OUTST_W-1:0]    outst;
  logic                  outst_full;

  logic        cmd_hs, cmd_ok, is_wr, rsp_open;
  logic        issue_c, req_hs, rsp_rdy_c, rsp_hs;
  logic [31:0] addr_sum;

  mem_outst_cnt #(
    .MAX_OUTST(MAX_OUTST)
  ) u_outst (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (req_hs),
    .dec   (rsp_hs),
    .cnt   (outst),
    .full  (outst_full)
  );

  // Handshake and issue qualifiers shared by next-state and output logic.
  always_comb begin
    cmd_hs       = cmd_val_i && (state_q == IDLE) && !rst_i;
    cmd_ok       = (cmd_len_i != '0) && (cmd_len_i <= LEN_WIDTH'(MAX_BURST));
    is_wr        = (typ_q == REQ_WR);
    issue_c      = (state_q == RUN) && (issued_q < len_q) && !outst_full &&
                   (!is_wr || wdata_val_i);
    req_hs       = issue_c && mem_req_rdy_i;
    // Responses with nothing outstanding are never acknowledged.
    rsp_open     = ((state_q == RUN) || (state_q == DRAIN)) && (outst != '0);
    rsp_rdy_c    = rsp_open && (is_wr || rdata_rdy_i);
    rsp_hs       = mem_rsp_val_i && rsp_rdy_c;
    received_nxt = received_q + LEN_WIDTH'(rsp_hs);
    addr_sum     = 32'(base_q) + 32'(issued_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs && cmd_ok) state_d = RUN;
      RUN:     if (req_hs && (issued_q + LEN_WIDTH'(1) == len_q)) state_d = DRAIN;
      DRAIN:   if (received_nxt == len_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst context and progress counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      typ_q      <= REQ_RD;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= cmd_hs && !cmd_ok;
      if (cmd_hs && cmd_ok) begin
        typ_q      <= req_typ_e'(cmd_typ_i);
        base_q     <= cmd_addr_i;
        len_q      <= cmd_len_i;
        issued_q   <= '0;
        received_q <= '0;
      end else begin
        if (req_hs) issued_q <= issued_q + LEN_WIDTH'(1);
        received_q <= received_nxt;
      end
    end
  end

  always_comb begin
    cmd_rdy_o      = (state_q == IDLE) && !rst_i;
    cmd_err_o      = err_q;
    done_o         = (state_q == DONE);
    mem_req_val_o  = issue_c;
    mem_req_typ_o  = typ_q;
    mem_req_addr_o = ADDR_WIDTH'(addr_sum % MEM_SIZE);
    mem_req_data_o = (is_wr && issue_c) ? wdata_i : '0;
    wdata_rdy_o    = is_wr && req_hs;
    mem_rsp_rdy_o  = rsp_rdy_c;
    rdata_val_o    = !is_wr && rsp_open && mem_rsp_val_i;
    rdata_o        = (!is_wr && rsp_open) ? mem_rsp_data_i : '0;
    rdata_last_o   = rdata_val_o && (received_q == len_q - LEN_WIDTH'(1));
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a behavioural memory and burst model.
module tb_mem_burst_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 7;
  localparam int unsigned LW = 5;
  localparam int unsigned MSZ = 128;
  localparam int unsigned MOUT = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_val_i, cmd_rdy_o, cmd_typ_i, cmd_err_o;
  logic [AW-1:0] cmd_addr_i;
  logic [LW-1:0] cmd_len_i;
  logic          wdata_val_i, wdata_rdy_o;
  logic [DW-1:0] wdata_i;
  logic          rdata_val_o, rdata_rdy_i, rdata_last_o;
  logic [DW-1:0] rdata_o;
  logic          done_o;
  logic          mem_req_val_o, mem_req_rdy_i, mem_req_typ_o;
  logic [AW-1:0] mem_req_addr_o;
  logic [DW-1:0] mem_req_data_o;
  logic          mem_rsp_val_i, mem_rsp_rdy_o;
  logic [DW-1:0] mem_rsp_data_i;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] mem [MSZ];

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  mem_burst_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_val_i(cmd_val_i), .cmd_rdy_o(cmd_rdy_o), .cmd_typ_i(cmd_typ_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_err_o(cmd_err_o),
    .wdata_val_i(wdata_val_i), .wdata_rdy_o(wdata_rdy_o), .wdata_i(wdata_i),
    .rdata_val_o(rdata_val_o), .rdata_rdy_i(rdata_rdy_i), .rdata_o(rdata_o),
    .rdata_last_o(rdata_last_o), .done_o(done_o),
    .mem_req_val_o(mem_req_val_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_typ_o(mem_req_typ_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_data_o(mem_req_data_o),
    .mem_rsp_val_i(mem_rsp_val_i), .mem_rsp_rdy_o(mem_rsp_rdy_o),
    .mem_rsp_data_i(mem_rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {cmd_rdy_o, cmd_err_o, wdata_rdy_o, rdata_val_o, rdata_o, rdata_last_o,
            done_o, mem_req_val_o, mem_req_typ_o, mem_req_addr_o, mem_req_data_o,
            mem_rsp_rdy_o};
  endfunction

  // One burst against the memory model; expected traffic derives from base/len/data only.
  task automatic run_burst(input bit wr, input int base, input int len, input int lat,
                           input int rq_pct, input int rr_pct, input int wv_pct,
                           input bit pat, input int abort_it);
    logic [DW-1:0] wd[$];
    logic [DW-1:0] exp_rd[$];
    rsp_t q[$];
    rsp_t r;
    int n_req = 0, n_rsp = 0, n_rd = 0, n_wd = 0;
    int outst = 0, max_o = 0, last_rsp = -10, done_cnt = 0;
    bit rq, rs, stream;
    stream = (rq_pct >= 100) && (rr_pct >= 100) && (wv_pct >= 100) && (lat == 1);
    for (int i = 0; i < len; i++) begin
      wd.push_back(pat ? DW'(32'hA0 + i) : $urandom);
      exp_rd.push_back(mem[(base + i) % MSZ]);
    end
    @(negedge clk_i);
    cmd_val_i = 1'b1; cmd_typ_i = wr; cmd_addr_i = AW'(base); cmd_len_i = LW'(len);
    #1 chk("cmd_rdy_idle", cmd_rdy_o, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_val_i = 1'b0;
    for (int it = 0; it < 500 && done_cnt == 0; it++) begin
      if (abort_it != 0 && it == abort_it) return;
      mem_req_rdy_i = ($urandom_range(99) < rq_pct);
      rdata_rdy_i   = ($urandom_range(99) < rr_pct);
      wdata_val_i   = wr && (n_wd < len) && ($urandom_range(99) < wv_pct);
      wdata_i       = wdata_val_i ? wd[n_wd] : $urandom;
      if (q.size() > 0 && q[0].due <= it) begin
        mem_rsp_val_i = 1'b1; mem_rsp_data_i = q[0].data;
      end else begin
        mem_rsp_val_i = 1'b0; mem_rsp_data_i = $urandom;
      end
      #1;
      if (outst == int'(MOUT)) chk("blocked_at_max", mem_req_val_o, 1'b0);
      rq = mem_req_val_o && mem_req_rdy_i;
      rs = mem_rsp_val_i && mem_rsp_rdy_o;
      if (it == 0 && (!wr || wdata_val_i)) chk("first_req_latency", mem_req_val_o, 1'b1);
      if (stream) chk("stream_req", rq, it < len);
      if (rq) begin
        chk("req_addr", mem_req_addr_o, AW'((base + n_req) % MSZ));
        chk("req_typ", mem_req_typ_o, wr);
        chk("req_data", mem_req_data_o, (wr && n_req < len) ? wd[n_req] : '0);
      end
      if (wr) begin
        if (wdata_val_i) chk("wdata_rdy", wdata_rdy_o, rq);
        chk("wr_no_rdata", rdata_val_o, 1'b0);
        if (mem_rsp_val_i) chk("wr_rsp_rdy", mem_rsp_rdy_o, 1'b1);
      end else begin
        if (mem_rsp_val_i) chk("rd_rsp_rdy", mem_rsp_rdy_o, rdata_rdy_i);
        if (rdata_val_o && rdata_rdy_i) begin
          chk("rdata", rdata_o, n_rd < len ? exp_rd[n_rd] : '0);
          chk("rdata_last", rdata_last_o, n_rd == len - 1);
          n_rd++;
        end
      end
      if (done_o) begin
        chk("done_timing", it, last_rsp + 1);
        chk("done_rsp_count", n_rsp, len);
        chk("done_cmd_rdy", cmd_rdy_o, 1'b0);
        done_cnt++;
      end
      @(posedge clk_i);
      if (rq) begin
        if (wr) mem[mem_req_addr_o] = mem_req_data_o;
        r.data = wr ? $urandom : mem[mem_req_addr_o];
        r.due  = it + lat;
        q.push_back(r);
        n_req++;
      end
      if (rs) begin
        void'(q.pop_front());
        n_rsp++;
        last_rsp = it;
      end
      if (wr && wdata_val_i && wdata_rdy_o) n_wd++;
      outst = outst + int'(rq) - int'(rs);
      if (outst > max_o) max_o = outst;
      @(negedge clk_i);
    end
    chk("done_seen", done_cnt, 1);
    #1;
    chk("done_single", done_o, 1'b0);
    chk("idle_after_done", cmd_rdy_o, 1'b1);
    chk("req_count", n_req, len);
    chk("outst_bound", max_o <= int'(MOUT), 1'b1);
    if (lat >= 3 && len >= 3 && rq_pct >= 100 && rr_pct >= 100) chk("outst_reached_max", max_o, MOUT);
    if (wr) begin
      chk("wdata_count", n_wd, len);
      for (int i = 0; i < len; i++) chk("mem_written", mem[(base + i) % MSZ], wd[i]);
    end else begin
      chk("rdata_count", n_rd, len);
    end
  endtask

  task automatic bad_cmd(input int len);
    @(negedge clk_i);
    mem_req_rdy_i = 1'b1; mem_rsp_val_i = 1'b0; wdata_val_i = 1'b0;
    cmd_val_i = 1'b1; cmd_typ_i = 1'b0; cmd_addr_i = AW'($urandom); cmd_len_i = LW'(len);
    #1 chk("err_cmd_rdy", cmd_rdy_o, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_val_i = 1'b0;
    #1;
    chk("err_pulse", cmd_err_o, 1'b1);
    chk("err_no_req", mem_req_val_o, 1'b0);
    chk("err_stay_idle", cmd_rdy_o, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("err_single", cmd_err_o, 1'b0);
    chk("err_no_req_after", mem_req_val_o, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < int'(MSZ); i++) mem[i] = $urandom;
    rst_i = 1'b1; cmd_val_i = 1'b0; cmd_typ_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wdata_val_i = 1'b0; wdata_i = '0; rdata_rdy_i = 1'b0; mem_req_rdy_i = 1'b0;
    mem_rsp_val_i = 1'b0; mem_rsp_data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1 chk("reset_outputs", all_outs(), '0);
    rst_i = 1'b0;
    #1 chk("reset_release_idle", cmd_rdy_o, 1'b1);

    run_burst(1'b1, 'h10, 4, 1, 100, 100, 100, 1'b1, 0);
    run_burst(1'b0, 'h10, 4, 1, 100, 100, 100, 1'b0, 0);
    for (int i = 0; i < 4; i++) chk("write_pattern", mem['h10 + i], DW'(32'hA0 + i));
    run_burst(1'b0, 126, 4, 1, 100, 100, 100, 1'b0, 0);
    run_burst(1'b0, 40, 8, 3, 100, 100, 100, 1'b0, 0);
    run_burst(1'b1, 120, 6, 3, 100, 100, 100, 1'b0, 0);

    bad_cmd(0);
    bad_cmd(17);
    bad_cmd(31);

    for (int n = 0; n < 8; n++) begin
      run_burst(1'($urandom_range(1)), $urandom_range(127), $urandom_range(16, 1),
                $urandom_range(4, 1), $urandom_range(100, 40), $urandom_range(100, 40),
                $urandom_range(100, 40), 1'b0, 0);
    end
    run_burst(1'b0, 5, 16, 2, 70, 60, 100, 1'b0, 0);

    run_burst(1'b0, 64, 8, 1, 100, 0, 100, 1'b0, 2);
    rst_i = 1'b1; mem_rsp_val_i = 1'b1; rdata_rdy_i = 1'b0;
    @(posedge clk_i);
    #1 chk("mid_reset_outputs", all_outs(), '0);
    @(negedge clk_i);
    rst_i = 1'b0; mem_rsp_val_i = 1'b0;
    #1 chk("mid_reset_idle", cmd_rdy_o, 1'b1);
    run_burst(1'b0, 77, 1, 1, 100, 100, 100, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
